regfile_wb_arbiter: RTL

- Shares the single register-file write port (rd_addr/rd_data/rd_wren) between two write-back requesters: req0 = ALU, req1 = load/store unit.
- Round-robin arbitration with valid/ready handshakes and a one-cycle registered output stage.
- Presents the in-flight write to the issue stage for hazard checking, and counts contention cycles for performance debug.
- Sits between the execute/memory stages and regfile.

---
 rtl/regfile_pkg.sv | 25 ++
 rtl/regfile_wb_arbiter_if.sv | 38 +++
 rtl/regfile_wb_arbiter_rr_arb2.sv | 42 ++++
 rtl/regfile_wb_arbiter.sv | 73 +++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package regfile_pkg;

    localparam int DATAWIDTH = 32;
    localparam int ADDRWIDTH = 5;
    localparam int CNTWIDTH  = 16;

    typedef struct packed {
        logic [ADDRWIDTH-1:0] addr;
        logic [DATAWIDTH-1:0] data;
    } wb_req_t;

    localparam logic [ADDRWIDTH-1:0] REG_ZERO = '0;

    localparam logic GNT_ALU = 1'b0;
    localparam logic GNT_LSU = 1'b1;

    // x0 is hard-wired zero, so a write to it is accepted but never reaches the regfile
    function automatic logic is_live_wr(input wb_req_t r);
        return r.addr != REG_ZERO;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back request/response bundle between the requesters, the arbiter and the regfile.
// Latency: none (wiring only).
// Backpressure: per-requester valid/ready; the regfile side never stalls.
interface regfile_wb_arbiter_if;
    import regfile_pkg::*;

    logic                 req0_valid_i;
    logic [ADDRWIDTH-1:0] req0_addr_i;
    logic [DATAWIDTH-1:0] req0_data_i;
    logic                 req0_ready_o;
    logic                 req1_valid_i;
    logic [ADDRWIDTH-1:0] req1_addr_i;
    logic [DATAWIDTH-1:0] req1_data_i;
    logic                 req1_ready_o;
    logic [ADDRWIDTH-1:0] rd_addr_o;
    logic [DATAWIDTH-1:0] rd_data_o;
    logic                 rd_wren_o;
    logic                 wb_pend_valid_o;
    logic [ADDRWIDTH-1:0] wb_pend_addr_o;
    logic [CNTWIDTH-1:0]  conflict_cnt_o;

    modport slave (
        input  req0_valid_i, req0_addr_i, req0_data_i,
        input  req1_valid_i, req1_addr_i, req1_data_i,
        output req0_ready_o, req1_ready_o,
        output rd_addr_o, rd_data_o, rd_wren_o,
        output wb_pend_valid_o, wb_pend_addr_o, conflict_cnt_o
    );

    modport master (
        output req0_valid_i, req0_addr_i, req0_data_i,
        output req1_valid_i, req1_addr_i, req1_data_i,
        input  req0_ready_o, req1_ready_o,
        input  rd_addr_o, rd_data_o, rd_wren_o,
        input  wb_pend_valid_o, wb_pend_addr_o, conflict_cnt_o
    );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-input round-robin arbiter; owns the last-grant pointer.
// Latency: grant is combinational from req in the same cycle.
// Backpressure: no grants at all while reset is asserted.
module rr_arb2
    import regfile_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last_grant_q;
    logic last_grant_d;

    always_comb begin
        gnt          = 2'b00;
        last_grant_d = last_grant_q;
        if (rst_ni) begin
            // On contention the side that did not win last time goes first
            if (req[GNT_ALU] && (!req[GNT_LSU] || (last_grant_q == GNT_LSU))) begin
                gnt[GNT_ALU] = 1'b1;
            end else if (req[GNT_LSU]) begin
                gnt[GNT_LSU] = 1'b1;
            end
        end
        if (gnt[GNT_ALU]) begin
            last_grant_d = GNT_ALU;
        end else if (gnt[GNT_LSU]) begin
            last_grant_d = GNT_LSU;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_grant_q <= GNT_LSU;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the regfile write port between ALU (req0) and LSU (req1) write-backs.
// Latency: 1 cycle from accept to rd_wren_o; 1 write per cycle sustained.
// Backpressure: only the losing requester stalls; the regfile side always drains.
module regfile_wb_arbiter
    import regfile_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    regfile_wb_arbiter_if.slave  wb
);

    logic [1:0]          arb_req;
    logic [1:0]          arb_gnt;
    logic                acc_vld;
    wb_req_t             req0_dat;
    wb_req_t             req1_dat;
    wb_req_t             sel_dat;

    wb_req_t             stage_q;
    wb_req_t             stage_d;
    logic                wren_q;
    logic                wren_d;
    logic [CNTWIDTH-1:0] cnt_q;
    logic [CNTWIDTH-1:0] cnt_d;

    assign arb_req = {wb.req1_valid_i, wb.req0_valid_i};

    rr_arb2 u_arb (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req    (arb_req),
        .gnt    (arb_gnt)
    );

    assign wb.req0_ready_o = arb_gnt[GNT_ALU];
    assign wb.req1_ready_o = arb_gnt[GNT_LSU];

    always_comb begin
        req0_dat = '{addr: wb.req0_addr_i, data: wb.req0_data_i};
        req1_dat = '{addr: wb.req1_addr_i, data: wb.req1_data_i};
        acc_vld  = |arb_gnt;
        sel_dat  = arb_gnt[GNT_LSU] ? req1_dat : req0_dat;

        // Address/data follow every accept, including x0, and hold when idle
        stage_d  = acc_vld ? sel_dat : stage_q;
        wren_d   = acc_vld && is_live_wr(sel_dat);

        cnt_d    = cnt_q;
        if (wb.req0_valid_i && wb.req1_valid_i && (cnt_q != {CNTWIDTH{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stage_q <= '0;
            wren_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            stage_q <= stage_d;
            wren_q  <= wren_d;
            cnt_q   <= cnt_d;
        end
    end

    assign wb.rd_addr_o       = stage_q.addr;
    assign wb.rd_data_o       = stage_q.data;
    assign wb.rd_wren_o       = wren_q;
    assign wb.wb_pend_valid_o = wren_q;
    assign wb.wb_pend_addr_o  = stage_q.addr;
    assign wb.conflict_cnt_o  = cnt_q;

endmodule
